mem_port_array: RTL and testbench
=================================

// Module: mem_port_array
// PURPOSE
//   Parametrised register-based memory array with reset-time initial contents,
//   one write port, one registered read port, and a full flattened view of all entries.
//   Adds a valid/ready dump streamer that reads every entry out in address order.
//   Used as the general-purpose packed-array/memory-port block; for example,
//   10 x 32-bit entries preloaded with 0..9.
// PARAMETERS
//   WIDTH      32               entry width in bits (>=1)
//   DEPTH      10               number of entries (>=2)
//   AW         $clog2(DEPTH)    address width (derived; do not override)
//   INIT_MODE  1                reset contents: 0 = all zero; 1 = entry i holds i (zero-extended/truncated to WIDTH)
// PORTS
//   clk         in   1            clock; all state on rising edge
//   rst_n       in   1            asynchronous active-low reset
//   wr_en       in   1            write strobe
//   wr_addr     in   AW           write address
//   wr_data     in   WIDTH        write data
//   rd_en       in   1            read strobe
//   rd_addr     in   AW           read address
//   rd_data     out  WIDTH        read data, registered
//   rd_valid    out  1            rd_data valid (1-cycle pulse)
//   flat_out    out  WIDTH*DEPTH  all entries; entry i at [i*WIDTH +: WIDTH]
//   last_idx    out  WIDTH        constant DEPTH-1
//   dump_start  in   1            request a full dump
//   dump_valid  out  1            dump beat valid
//   dump_ready  in   1            consumer accepts the beat
//   dump_data   out  WIDTH        current dump entry
//   dump_addr   out  AW           address of the current dump entry
//   dump_last   out  1            current beat is entry DEPTH-1
//   busy        out  1            dump in progress
//   err_oob     out  1            sticky out-of-range address flag
// BEHAVIOUR
//   Reset (async assert, sync-released use):
//     - Entries load per INIT_MODE.
//     - rd_data=0, rd_valid=0, err_oob=0.
//     - Dump FSM goes to IDLE with idx=0.
//   Write:
//     - wr_en with wr_addr<DEPTH updates the entry at the next edge.
//     - wr_addr>=DEPTH: no write; err_oob set.
//   Read:
//     - rd_en at edge N gives rd_data=mem[rd_addr] and rd_valid=1 during cycle N+1.
//     - rd_valid=0 otherwise; rd_data holds its last value.
//     - Read and write to the same address in the same cycle is read-first:
//       rd_data returns the old value.
//     - rd_addr>=DEPTH returns rd_data=0 with rd_valid=1, and sets err_oob.
//   err_oob stays set until reset. wr and rd errors in the same cycle count as one set.
//   flat_out and last_idx:
//     - flat_out is driven combinationally from the array, so it shows a write
//       the cycle after the write edge.
//     - last_idx is a constant.
//   Dump FSM, states IDLE and STREAM:
//     - IDLE: dump_valid=0, busy=0. dump_start -> STREAM with idx=0.
//     - STREAM: dump_valid=1, busy=1, dump_addr=idx, dump_data=mem[idx] (live),
//       dump_last=(idx==DEPTH-1).
//     - dump_valid&dump_ready: idx++. If dump_last -> IDLE, idx=0.
//     - dump_ready low: the beat stalls. addr is held; data tracks writes to that entry.
//     - dump_start during STREAM is ignored (no restart).
//     - Writes during a dump are permitted; an entry is sampled when its beat is accepted.
//   Reset mid-dump: FSM returns to IDLE immediately, contents re-initialise,
//   and no partial beat is emitted after release.
// TESTING
//   1. Reset with defaults -> flat_out=320'h00000009_00000008_..._00000001_00000000,
//      last_idx=32'd9, err_oob=0.
//   2. wr 0xDEADBEEF@3, then rd@3 -> next cycle rd_valid=1, rd_data=0xDEADBEEF;
//      flat_out[127:96]=0xDEADBEEF.
//   3. Same-cycle wr 0x55@5 and rd@5 -> rd_data=5 (old). A following rd@5 -> 0x55.
//   4. wr@10 and rd@12 -> no entry changes, rd_data=0, err_oob=1 and stays 1
//      through later legal accesses.
//   5. dump_start with dump_ready toggling 1,0,1,... -> exactly 10 accepted beats,
//      data 0..9, dump_last only on addr 9, then busy=0.
//   6. Assert rst_n at dump beat 4 after wr 0xAA@7 -> busy=0 at once, entry 7=7 again;
//      a new dump streams 0..9.

Source files
------------

// File: rtl/mem_port_array_if.sv
// Bundles the write, read, flat-view and dump-stream signals of mem_port_array.
// Latency: none (wires only).
// Backpressure: the dump stream uses dump_valid/dump_ready; other signals are strobes.
interface mem_port_array_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 10,
    parameter int AW    = $clog2(DEPTH)
);
    // write port
    logic                   wr_en;
    logic [AW-1:0]          wr_addr;
    logic [WIDTH-1:0]       wr_data;
    // read port
    logic                   rd_en;
    logic [AW-1:0]          rd_addr;
    logic [WIDTH-1:0]       rd_data;
    logic                   rd_valid;
    // whole-array view
    logic [WIDTH*DEPTH-1:0] flat_out;
    logic [WIDTH-1:0]       last_idx;
    // dump streamer
    logic                   dump_start;
    logic                   dump_valid;
    logic                   dump_ready;
    logic [WIDTH-1:0]       dump_data;
    logic [AW-1:0]          dump_addr;
    logic                   dump_last;
    logic                   busy;
    // status
    logic                   err_oob;

    modport master (
        output wr_en, wr_addr, wr_data,
        output rd_en, rd_addr,
        output dump_start, dump_ready,
        input  rd_data, rd_valid,
        input  flat_out, last_idx,
        input  dump_valid, dump_data, dump_addr, dump_last, busy,
        input  err_oob
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        input  rd_en, rd_addr,
        input  dump_start, dump_ready,
        output rd_data, rd_valid,
        output flat_out, last_idx,
        output dump_valid, dump_data, dump_addr, dump_last, busy,
        output err_oob
    );
endinterface

// File: rtl/mem_port_array.sv
// Register-array memory: one write port, one registered read port, flat view, dump streamer.
// Latency: write visible next cycle; read data one cycle after rd_en; dump data is live.
// Backpressure: dump beat holds its address while dump_ready is low; other ports never stall.
module mem_port_array #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 10,
    parameter int AW        = $clog2(DEPTH),
    parameter int INIT_MODE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_port_array_if.slave  bus
);

    // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } dump_state_t;

    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [WIDTH-1:0]       rd_data_q;
    logic                   rd_valid_q;
    logic                   err_oob_q;
    logic                   err_oob_d;
    dump_state_t            state_q;
    dump_state_t            state_d;
    logic [AW-1:0]          idx_q;
    logic [AW-1:0]          idx_d;

    logic                   wr_oob;
    logic                   rd_oob;
    logic                   dump_valid;
    logic                   dump_busy;
    logic                   dump_last;
    logic [WIDTH*DEPTH-1:0] flat;

    assign wr_oob = ({1'b0, bus.wr_addr} >= DEPTH_W);
    assign rd_oob = ({1'b0, bus.rd_addr} >= DEPTH_W);

    // Array storage: reset loads the preset pattern, in-range writes update one entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= (INIT_MODE == 1) ? WIDTH'(i) : '0;
            end
        end else if (bus.wr_en && !wr_oob) begin
            mem_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Registered read; sees the pre-write contents, so same-address read/write is read-first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                rd_data_q <= rd_oob ? '0 : mem_q[bus.rd_addr];
            end
        end
    end

    // Sticky error: any out-of-range write or read attempt sets it until reset.
    always_comb begin
        err_oob_d = err_oob_q | (bus.wr_en & wr_oob) | (bus.rd_en & rd_oob);
    end

    // Error flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_oob_q <= 1'b0;
        end else begin
            err_oob_q <= err_oob_d;
        end
    end

    // Dump FSM state and beat index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Dump FSM next state: start only from IDLE, advance on each accepted beat, wrap to IDLE after the last.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        dump_valid = 1'b0;
        dump_busy  = 1'b0;
        dump_last  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.dump_start) begin
                    state_d = ST_STREAM;
                    idx_d   = '0;
                end
            end
            ST_STREAM: begin
                dump_valid = 1'b1;
                dump_busy  = 1'b1;
                dump_last  = (idx_q == LAST_A);
                if (bus.dump_ready) begin
                    if (dump_last) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Flattened view of every entry, entry i in slice i.
    always_comb begin
        flat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            flat[i*WIDTH +: WIDTH] = mem_q[i];
        end
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.err_oob    = err_oob_q;
    assign bus.flat_out   = flat;
    assign bus.last_idx   = WIDTH'(DEPTH - 1);
    assign bus.dump_valid = dump_valid;
    assign bus.busy       = dump_busy;
    assign bus.dump_last  = dump_last;
    assign bus.dump_addr  = idx_q;
    // Live entry: a stalled beat follows writes to its address until accepted.
    assign bus.dump_data  = mem_q[idx_q];

endmodule

// File: tb/tb_mem_port_array.sv
// Self-checking bench for mem_port_array with read and dump scoreboards.
// Latency: expects read data one cycle after rd_en; dump beats compared on acceptance.
// Backpressure: exercises dump_ready toggling and mid-dump reset.
module tb_mem_port_array;

    localparam int WIDTH = 32;
    localparam int DEPTH = 10;
    localparam int AW    = $clog2(DEPTH);

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
        logic             last;
    } beat_t;

    logic clk;
    logic rst_n;

    mem_port_array_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    mem_port_array #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INIT_MODE(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int               n_checks;
    int               n_fail;
    int               beat_cnt;
    logic [WIDTH-1:0] model [DEPTH];
    logic [WIDTH-1:0] rd_q [$];
    beat_t            dump_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH*DEPTH-1:0] obs,
                       input logic [WIDTH*DEPTH-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH*DEPTH-1:0] model_flat();
        logic [WIDTH*DEPTH-1:0] f;
        f = '0;
        for (int i = 0; i < DEPTH; i++) f[i*WIDTH +: WIDTH] = model[i];
        return f;
    endfunction

    task automatic model_init();
        for (int i = 0; i < DEPTH; i++) model[i] = WIDTH'(i);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.rd_en      = 1'b0;
        bus.rd_addr    = '0;
        bus.dump_start = 1'b0;
        bus.dump_ready = 1'b0;
        model_init();
        rd_q.delete();
        dump_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One cycle of port activity; expected read data is taken before the write (read-first).
    task automatic op(input logic we, input int wa, input logic [WIDTH-1:0] wd,
                      input logic re, input int ra);
        bus.wr_en   = we;
        bus.wr_addr = AW'(wa);
        bus.wr_data = wd;
        bus.rd_en   = re;
        bus.rd_addr = AW'(ra);
        if (re) rd_q.push_back((ra >= DEPTH) ? '0 : model[ra]);
        if (we && wa < DEPTH) model[wa] = wd;
        step();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    task automatic push_dump();
        beat_t b;
        for (int i = 0; i < DEPTH; i++) begin
            b.addr = AW'(i);
            b.data = model[i];
            b.last = (i == DEPTH - 1);
            dump_q.push_back(b);
        end
    endtask

    task automatic dump_all(input bit toggle);
        int  b0;
        int  cyc;
        logic r;
        push_dump();
        b0 = beat_cnt;
        bus.dump_start = 1'b1;
        step();
        bus.dump_start = 1'b0;
        cyc = 0;
        r   = 1'b1;
        while (bus.busy && cyc < 200) begin
            bus.dump_ready = r;
            bus.dump_start = (cyc == 3);
            step();
            if (toggle) r = ~r;
            cyc++;
        end
        bus.dump_ready = 1'b0;
        bus.dump_start = 1'b0;
        chk("dump_timeout", (cyc < 200), 1);
        chk("dump_beats", beat_cnt - b0, DEPTH);
        chk("dump_busy_end", bus.busy, 0);
        chk("dump_q_empty", dump_q.size(), 0);
    endtask

    // Read scoreboard: every rd_valid pops one expected value.
    always @(negedge clk) begin
        if (rst_n && bus.rd_valid) begin
            if (rd_q.size() == 0) chk("rd_unexpected", bus.rd_valid, 0);
            else chk("rd_data", bus.rd_data, rd_q.pop_front());
        end
    end

    // Dump scoreboard: every accepted beat pops one expected beat.
    always @(negedge clk) begin
        beat_t e;
        if (rst_n && bus.dump_valid && bus.dump_ready) begin
            beat_cnt++;
            if (dump_q.size() == 0) begin
                chk("dump_unexpected", bus.dump_valid, 0);
            end else begin
                e = dump_q.pop_front();
                chk("dump_addr", bus.dump_addr, e.addr);
                chk("dump_data", bus.dump_data, e.data);
                chk("dump_last", bus.dump_last, e.last);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int cyc;
        n_checks = 0;
        n_fail   = 0;
        beat_cnt = 0;

        // reset contents and outputs
        do_reset();
        chk("rst_flat", bus.flat_out, model_flat());
        chk("rst_flat_e9", bus.flat_out[319:288], 32'd9);
        chk("rst_last_idx", bus.last_idx, 32'd9);
        chk("rst_err", bus.err_oob, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_busy", bus.busy, 0);

        // write then read back
        op(1, 3, 32'hDEADBEEF, 0, 0);
        chk("flat_e3", bus.flat_out[127:96], 32'hDEADBEEF);
        op(0, 0, 0, 1, 3);
        step();

        // same-cycle read/write is read-first
        op(1, 5, 32'h55, 1, 5);
        op(0, 0, 0, 1, 5);
        step();
        chk("rd_hold", bus.rd_data, 32'h55);
        chk("rd_valid_idle", bus.rd_valid, 0);

        // out-of-range accesses
        chk("err_pre", bus.err_oob, 0);
        op(1, 10, 32'h12345678, 0, 0);
        chk("oob_wr_flat", bus.flat_out, model_flat());
        chk("oob_wr_err", bus.err_oob, 1);
        op(0, 0, 0, 1, 12);
        step();
        op(1, 2, 32'hCAFE, 1, 3);
        step();
        chk("err_sticky", bus.err_oob, 1);
        chk("flat_after_legal", bus.flat_out, model_flat());
        chk("rd_q_empty", rd_q.size(), 0);

        // full dump with toggling backpressure, from fresh contents
        do_reset();
        chk("err_cleared", bus.err_oob, 0);
        dump_all(1'b1);

        // reset in the middle of a dump
        op(1, 7, 32'hAA, 0, 0);
        chk("flat_e7_aa", bus.flat_out[255:224], 32'hAA);
        push_dump();
        b0 = beat_cnt;
        bus.dump_start = 1'b1;
        step();
        bus.dump_start = 1'b0;
        bus.dump_ready = 1'b1;
        cyc = 0;
        while (!(bus.dump_valid && bus.dump_addr == AW'(4)) && cyc < 50) begin
            step();
            cyc++;
        end
        chk("abort_reach", (cyc < 50), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_valid", bus.dump_valid, 0);
        chk("abort_e7", bus.flat_out[255:224], 32'd7);
        chk("abort_beats", beat_cnt - b0, 4);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_valid", bus.dump_valid, 0);
            step();
        end
        dump_all(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
